mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Sequential multiply-accumulate stage that consumes the 8-bit product of the existing `bit4multiplier` and sums `N_TERMS` consecutive products into a dot-product result. It sits directly downstream of the 4-bit multiplier in the ALU datapath. Operands arrive on a valid/ready handshake, and the finished sum is presented on a second valid/ready handshake.

## Interface
Parameters:
- `ACC_W`, default 12: accumulator and result width in bits; must be ≥ 8.
- `N_TERMS`, default 4: number of products summed per result; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair is valid.
- `in_ready`  out  1  block accepts an operand pair this cycle.
- `multiplicand`  in  4  unsigned operand A.
- `multiplier_input`  in  4  unsigned operand B.
- `out_valid`  out  1  `acc_out` holds a completed dot product.
- `out_ready`  in  1  consumer takes the result this cycle.
- `acc_out`  out  ACC_W  accumulated sum (registered).
- `overflow`  out  1  sticky flag; set when any accumulation in the current result carried out of ACC_W.

## Operation
- Input handshake: a term is accepted on an edge where `in_valid && in_ready` is true. Operands are sampled only at that edge.
- Stage 1 (product register):
  - On an accepted term, `prod_q <= multiplicand*multiplier_input`. The product comes from a `bit4multiplier` instance.
  - `prod_v <= 1` on an accepted term, otherwise `prod_v <= 0`.
- Stage 2 (accumulate):
  - When `prod_v` is set, `acc <= acc + zero-extended prod_q`, modulo 2^ACC_W.
  - `overflow |= carry-out` of that addition.
  - `acc_cnt` increments.
- `issued_cnt` counts accepted terms in the current result.
- FSM states:
  - ACCUM: `in_ready = !rst && issued_cnt < N_TERMS`; `out_valid = 0`. When the accumulate of term N_TERMS happens, the next state is HOLD.
  - HOLD: `out_valid = 1`; `in_ready = 0`; `acc_out` and `overflow` are stable. On `out_valid && out_ready`: clear `acc`, `overflow`, `issued_cnt` and `acc_cnt`, then go to ACCUM.
- `out_ready` is ignored in ACCUM. `in_valid` is ignored whenever `in_ready` is 0.
- Reset values:
  - State ACCUM.
  - `acc_out`, `prod_q`, `prod_v`, `issued_cnt`, `acc_cnt`, `overflow`, `out_valid` all 0.
  - `in_ready` is forced to 0 while `rst` is high and reads 1 on the first cycle after `rst` is released.
- Reset mid-operation discards the partial sum and any in-flight `prod_q`. No output is produced for the aborted result.

## Timing
- Throughput: one term per cycle with no bubbles while in ACCUM.
- Latency: term N_TERMS accepted at edge E → accumulated at E+1 → `out_valid` is high in the cycle after E+1.
- Minimum result period: N_TERMS + 2 cycles when `out_ready` is held high.
- After the result handshake edge H, `in_ready` is 1 in the cycle after H. There is no overlap between consecutive results.
- `acc_out` is held unchanged for the whole HOLD interval, regardless of `in_valid` or `multiplicand`/`multiplier_input` activity.
- Wrap-around: the sum wraps modulo 2^ACC_W, and `overflow` stays set until the result is consumed or reset.

## Structure
- Shared package `alu_pkg` holds:
  - the `mac_state_t` enum {ACCUM, HOLD};
  - the default constants `MAC_ACC_W = 12` and `MAC_N_TERMS = 4`;
  - the operand width constant `OPND_W = 4`.
- The one sub-module is `bit4multiplier`, instantiated unchanged (ports `multiplicand`, `multiplier_input`, `A_B`). No other hierarchy.
- Counter width is `$clog2(N_TERMS+1)`.

## Test plan
- Reset: assert `rst` for 3 cycles with `in_valid` = 1 → `in_ready` = 0, `out_valid` = 0, `acc_out` = 0, `overflow` = 0. After release, `in_ready` = 1 on the next cycle.
- Back-to-back dot product, defaults: input pairs (3,2), (5,6), (7,2), (9,5) on consecutive cycles → `out_valid` rises 2 edges after the 4th handshake, `acc_out` = 95, `overflow` = 0.
- Backpressure: hold `out_ready` = 0 for 5 cycles in HOLD while driving (15,15) with `in_valid` = 1 → `acc_out` stays 95 and `in_ready` stays 0. On release, the next result (1,1)×4 gives 4, not 99.
- Gapped input: apply the same four pairs with `in_valid` toggling every other cycle → `acc_out` = 95, `out_valid` rises 2 edges after the last handshake.
- Overflow (`ACC_W` = 8): input four × (15,15) → `acc_out` = 132 (900 mod 256), `overflow` = 1. After consuming the result, the next result's `overflow` = 0.
- Reset mid-operation: accept (15,15) twice, pulse `rst` on the cycle `prod_v` = 1, then input (1,1)×4 → `acc_out` = 4, `overflow` = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: MAC state encoding, default MAC sizing
// and the operand width of the 4-bit multiplier.
package alu_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    localparam int MAC_ACC_W   = 12;
    localparam int MAC_N_TERMS = 4;
    localparam int OPND_W      = 4;

endpackage

// File: rtl/bit4multiplier.sv
// Unsigned 4x4 combinational multiplier producing an 8-bit product.
module bit4multiplier
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0]   multiplicand,
    input  logic [OPND_W-1:0]   multiplier_input,
    output logic [2*OPND_W-1:0] A_B
);

    logic [2*OPND_W-1:0] a_b_s;
    logic [2*OPND_W-1:0] mcand_ext_s;

    assign mcand_ext_s = {{OPND_W{1'b0}}, multiplicand};

    // Shift-and-add over the multiplier bits to form the product.
    always_comb begin
        a_b_s = {(2*OPND_W){1'b0}};
        for (int i = 0; i < OPND_W; i++) begin
            if (multiplier_input[i]) begin
                a_b_s = a_b_s + (mcand_ext_s << i);
            end else begin
                a_b_s = a_b_s;
            end
        end
    end

    assign A_B = a_b_s;

endmodule

// File: rtl/mac_accumulator.sv
// Two-stage multiply-accumulate: registers the product of each accepted
// operand pair, then sums N_TERMS products into a registered result that is
// held on a valid/ready output handshake until consumed.
module mac_accumulator
    import alu_pkg::*;
#(
    parameter int ACC_W   = MAC_ACC_W,
    parameter int N_TERMS = MAC_N_TERMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] multiplicand,
    input  logic [OPND_W-1:0] multiplier_input,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    localparam int CNT_W  = $clog2(N_TERMS + 1);
    localparam int PROD_W = 2 * OPND_W;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TERMS = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(N_TERMS - 1);

    mac_state_t          state_q,      state_d;
    logic [PROD_W-1:0]   prod_q,       prod_d;
    logic                prod_v_q,     prod_v_d;
    logic [ACC_W-1:0]    acc_q,        acc_d;
    logic                overflow_q,   overflow_d;
    logic [CNT_W-1:0]    issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0]    acc_cnt_q,    acc_cnt_d;
    logic                out_valid_q,  out_valid_d;

    logic [PROD_W-1:0]   prod_s;
    logic                in_ready_s;
    logic                accept_s;
    logic [ACC_W:0]      sum_s;

    bit4multiplier u_mult (
        .multiplicand     (multiplicand),
        .multiplier_input (multiplier_input),
        .A_B              (prod_s)
    );

    // Accept terms only while accumulating, below the term budget and out of reset.
    always_comb begin
        if (rst) begin
            in_ready_s = 1'b0;
        end else if ((state_q == ACCUM) && (issued_cnt_q < CNT_TERMS)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_s;

    // Extra top bit of the sum captures the carry-out of the accumulate.
    assign sum_s = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

    // Next-state logic for the product stage, accumulator, counters and FSM.
    always_comb begin
        state_d      = state_q;
        prod_d       = prod_q;
        prod_v_d     = 1'b0;
        acc_d        = acc_q;
        overflow_d   = overflow_q;
        issued_cnt_d = issued_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        out_valid_d  = out_valid_q;

        if (accept_s) begin
            prod_d       = prod_s;
            prod_v_d     = 1'b1;
            issued_cnt_d = issued_cnt_q + CNT_ONE;
        end else begin
            prod_d       = prod_q;
            prod_v_d     = 1'b0;
        end

        case (state_q)
            ACCUM: begin
                if (prod_v_q) begin
                    acc_d      = sum_s[ACC_W-1:0];
                    overflow_d = overflow_q | sum_s[ACC_W];
                    acc_cnt_d  = acc_cnt_q + CNT_ONE;
                    if (acc_cnt_q == CNT_FINAL) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                    end
                end else begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d        = {ACC_W{1'b0}};
                    overflow_d   = 1'b0;
                    issued_cnt_d = CNT_ZERO;
                    acc_cnt_d    = CNT_ZERO;
                    state_d      = ACCUM;
                    out_valid_d  = 1'b0;
                end else begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; aborts any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            prod_q       <= {PROD_W{1'b0}};
            prod_v_q     <= 1'b0;
            acc_q        <= {ACC_W{1'b0}};
            overflow_q   <= 1'b0;
            issued_cnt_q <= CNT_ZERO;
            acc_cnt_q    <= CNT_ZERO;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prod_q       <= prod_d;
            prod_v_q     <= prod_v_d;
            acc_q        <= acc_d;
            overflow_q   <= overflow_d;
            issued_cnt_q <= issued_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a 12-bit and an 8-bit instance share stimulus;
// a transaction-level model (list of accepted products with their accept
// edge) predicts every output on every cycle.
module tb_mac_accumulator;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] mc = 4'd0;
    logic [3:0] mp = 4'd0;
    logic       out_ready = 1'b0;

    logic        rdy12, ov12, ovf12;
    logic [11:0] acc12;
    logic        rdy8, ov8, ovf8;
    logic [7:0]  acc8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_W(12), .N_TERMS(N)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy12),
        .multiplicand(mc), .multiplier_input(mp), .out_valid(ov12),
        .out_ready(out_ready), .acc_out(acc12), .overflow(ovf12)
    );

    mac_accumulator #(.ACC_W(8), .N_TERMS(N)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .multiplicand(mc), .multiplier_input(mp), .out_valid(ov8),
        .out_ready(out_ready), .acc_out(acc8), .overflow(ovf8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_prod[$];
    int m_edge[$];
    int t = 0;

    // Products accepted at edge e are in the sum from edge e+1 on.
    function automatic int incl_count();
        int c = 0;
        foreach (m_prod[i]) if (m_edge[i] < t) c++;
        return c;
    endfunction

    function automatic int incl_sum();
        int s = 0;
        foreach (m_prod[i]) if (m_edge[i] < t) s += m_prod[i];
        return s;
    endfunction

    function automatic bit exp_in_ready();
        return !rst && (m_prod.size() < N);
    endfunction

    function automatic bit exp_out_valid();
        return (m_prod.size() == N) && (incl_count() == N);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_prod.delete();
            m_edge.delete();
        end else if (exp_out_valid() && out_ready) begin
            m_prod.delete();
            m_edge.delete();
        end else if (in_valid && (m_prod.size() < N)) begin
            m_prod.push_back(int'(mc) * int'(mp));
            m_edge.push_back(t + 1);
        end
        t = t + 1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int s;
        if (t > 0) begin
            s = incl_sum();
            check("in_ready12",  rdy12, exp_in_ready());
            check("in_ready8",   rdy8,  exp_in_ready());
            check("out_valid12", ov12,  exp_out_valid());
            check("out_valid8",  ov8,   exp_out_valid());
            check("acc_out12",   acc12, s % 4096);
            check("acc_out8",    acc8,  s % 256);
            check("overflow12",  ovf12, s >= 4096);
            check("overflow8",   ovf8,  s >= 256);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b);
        logic [31:0] av, bv;
        av = a;
        bv = b;
        in_valid = 1'b1;
        mc = av[3:0];
        mp = bv[3:0];
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (ov12 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("wait_out_valid", ov12, 1'b1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
    endtask

    int pa[4] = '{3, 5, 7, 9};
    int pb[4] = '{2, 6, 2, 5};

    initial begin
        // Reset held with in_valid asserted.
        in_valid = 1'b1;
        mc = 4'd3;
        mp = 4'd3;
        repeat (3) step();
        check("rst_in_ready",  rdy12, 1'b0);
        check("rst_out_valid", ov12,  1'b0);
        check("rst_acc_out",   acc12, 0);
        check("rst_overflow",  ovf12, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("release_in_ready", rdy12, 1'b1);

        // Back-to-back dot product.
        for (int i = 0; i < 4; i++) send(pa[i], pb[i]);
        check("b2b_not_yet_valid", ov12, 1'b0);
        step();
        check("b2b_valid_latency", ov12, 1'b1);
        check("b2b_acc", acc12, 95);
        check("b2b_model_sum", incl_sum(), 95);
        check("b2b_ovf", ovf12, 1'b0);

        // Backpressure while junk operands are offered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        mc = 4'd15;
        mp = 4'd15;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_acc_hold", acc12, 95);
            check("bp_in_ready", rdy12, 1'b0);
        end
        in_valid = 1'b0;
        consume();
        for (int i = 0; i < 4; i++) send(1, 1);
        wait_valid();
        check("bp_next_acc", acc12, 4);
        consume();

        // Gapped input.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(pa[i], pb[i]);
            step();
        end
        wait_valid();
        check("gap_acc", acc12, 95);
        consume();

        // Overflow on the 8-bit instance.
        for (int i = 0; i < 4; i++) send(15, 15);
        wait_valid();
        check("ovf_acc8", acc8, 132);
        check("ovf_flag8", ovf8, 1'b1);
        check("ovf_acc12", acc12, 900);
        check("ovf_flag12", ovf12, 1'b0);
        check("ovf_model_sum", incl_sum() % 256, 132);
        consume();
        for (int i = 0; i < 4; i++) send(2, 3);
        wait_valid();
        check("ovf_next_acc8", acc8, 24);
        check("ovf_next_flag8", ovf8, 1'b0);
        consume();

        // Reset while a product is in flight.
        send(15, 15);
        send(15, 15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 1);
        wait_valid();
        check("midrst_acc", acc12, 4);
        check("midrst_ovf", ovf8, 1'b0);
        consume();

        // Randomised traffic, checked by the per-cycle model comparison.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            mc        = 4'($urandom_range(0, 15));
            mp        = 4'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
